// File: rtl/pr_bridge_timer_if.sv
// pr_bridge_timer_if: CPU side-bus between the MEM stage (master) and a
// memory-mapped device (slave).
//   PrAddr  - word address driven by the CPU
//   PrWD    - write data
//   IOWrite - one-cycle write strobe per store
//   PrRD    - read data returned combinationally by the device
interface pr_bridge_timer_if;
    logic [31:2] PrAddr;
    logic [31:0] PrWD;
    logic        IOWrite;
    logic [31:0] PrRD;

    modport master (output PrAddr, output PrWD, output IOWrite, input PrRD);
    modport slave  (input PrAddr, input PrWD, input IOWrite, output PrRD);
endinterface

// File: rtl/pr_bridge_timer.sv
// pr_bridge_timer: side-bus responder holding a count-down timer, a 32-bit
// output port and a 32-bit sampled input port in a 32-byte window at BASE.
//   clk     - rising-edge clock
//   rst     - synchronous reset, active low
//   bus     - CPU side-bus (slave modport): PrAddr, PrWD, IOWrite, PrRD
//   HWInt   - interrupt lines; [2] = timer IRQ & IM, [7:3] = 0
//   dev_in  - external input port, sampled every cycle
//   dev_out - external output port register
module pr_bridge_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic               clk,
    input  logic               rst,
    pr_bridge_timer_if.slave   bus,
    output logic [7:2]         HWInt,
    input  logic [31:0]        dev_in,
    output logic [31:0]        dev_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PRESET = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_OUT    = 3'd4;
    localparam logic [2:0] OFF_IN     = 3'd5;

    logic [1:0]  state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic        irq_q, irq_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic [31:0] out_q, out_d;
    logic [31:0] in_q, in_d;

    logic        in_win;
    logic [2:0]  off;
    logic        wr_ctrl, wr_preset, wr_out;
    logic        irq_set, irq_clr_fsm, fsm_clr_en;

    assign in_win    = (bus.PrAddr[31:5] == BASE[31:5]);
    assign off       = bus.PrAddr[4:2];
    assign wr_ctrl   = bus.IOWrite && in_win && (off == OFF_CTRL);
    assign wr_preset = bus.IOWrite && in_win && (off == OFF_PRESET);
    assign wr_out    = bus.IOWrite && in_win && (off == OFF_OUT);

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        mode_d      = mode_q;
        im_d        = im_q;
        irq_d       = irq_q;
        preset_d    = preset_q;
        count_d     = count_q;
        out_d       = out_q;
        in_d        = dev_in;
        irq_set     = 1'b0;
        irq_clr_fsm = 1'b0;
        fsm_clr_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q <= 32'd1) begin
                    count_d = '0;
                    irq_set = 1'b1;
                    state_d = S_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            S_INT: begin
                // Only MODE=01 reloads; 10/11 behave as one-shot.
                if (mode_q == 2'b01) begin
                    irq_clr_fsm = 1'b1;
                    state_d     = S_LOAD;
                end else begin
                    fsm_clr_en = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // CPU write to CTRL overrides the FSM's one-shot EN clear.
        if (fsm_clr_en) en_d = 1'b0;
        if (wr_ctrl) begin
            en_d   = bus.PrWD[0];
            mode_d = bus.PrWD[2:1];
            im_d   = bus.PrWD[3];
        end
        if (wr_preset) preset_d = bus.PrWD;
        if (wr_out)    out_d    = bus.PrWD;

        // A new IRQ on the same edge as a clear is kept.
        if (wr_ctrl || wr_preset || irq_clr_fsm) irq_d = 1'b0;
        if (irq_set) irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= '0;
            im_q     <= 1'b0;
            irq_q    <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            in_q     <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            irq_q    <= irq_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            out_q    <= out_d;
            in_q     <= in_d;
        end
    end

    always_comb begin
        bus.PrRD = '0;
        if (in_win) begin
            case (off)
                OFF_CTRL:   bus.PrRD = {27'b0, irq_q, im_q, mode_q, en_q};
                OFF_PRESET: bus.PrRD = preset_q;
                OFF_COUNT:  bus.PrRD = count_q;
                OFF_OUT:    bus.PrRD = out_q;
                OFF_IN:     bus.PrRD = in_q;
                default:    bus.PrRD = '0;
            endcase
        end
    end

    assign HWInt   = {5'b0, irq_q & im_q};
    assign dev_out = out_q;

endmodule
